// File: rtl/dsp_slice_pipe.sv
// Two-lane signed pre-adder/multiplier slice with coefficient banks, a
// configurable-depth pipeline and a saturating accumulator / cascade adder.
module dsp_slice_pipe #(
  parameter int A_W        = 19,
  parameter int B_W        = 18,
  parameter int COEF_DEPTH = 8,
  parameter int PIPE       = 2,
  parameter int ACC_W      = 64,
  parameter int SAT        = 1,
  localparam int CS_W      = $clog2(COEF_DEPTH),
  localparam int P_W       = A_W + B_W + 1
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic                    ena,
  input  logic                    in_valid,
  input  logic [1:0]              mode,
  input  logic                    preadd_en,
  input  logic                    sub,
  input  logic                    negate,
  input  logic                    loadconst,
  input  logic                    clear_acc,
  input  logic                    coefmux,
  input  logic signed [A_W-1:0]   ay,
  input  logic signed [A_W-1:0]   az,
  input  logic signed [A_W-1:0]   by,
  input  logic signed [A_W-1:0]   bz,
  input  logic signed [B_W-1:0]   ax,
  input  logic signed [B_W-1:0]   bx,
  input  logic [CS_W-1:0]         coefsela,
  input  logic [CS_W-1:0]         coefselb,
  input  logic                    coef_we,
  input  logic                    coef_bank,
  input  logic [CS_W-1:0]         coef_waddr,
  input  logic signed [B_W-1:0]   coef_wdata,
  input  logic signed [ACC_W-1:0] chainin,
  input  logic signed [ACC_W-1:0] constant,
  output logic signed [P_W-1:0]   resulta,
  output logic signed [P_W-1:0]   resultb,
  output logic signed [ACC_W-1:0] chainout,
  output logic                    out_valid,
  output logic                    overflow
);

  localparam int PA_W  = A_W + 1;
  localparam int S_W   = P_W + 1;
  localparam int BUN_W = 5 + 2 * P_W + S_W + 2 * ACC_W;
  localparam int PQ    = (PIPE > 0) ? PIPE : 1;

  // Returns {overflow, sum}; the sum is clamped when SAT is set.
  function automatic logic [ACC_W:0] add_sat(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic [ACC_W:0]   wide;
    logic [ACC_W-1:0] res;
    logic             ovf;
    wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    ovf  = wide[ACC_W] ^ wide[ACC_W-1];
    res  = wide[ACC_W-1:0];
    if (ovf && SAT != 0) res = {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}};
    return {ovf, res};
  endfunction

  logic signed [B_W-1:0] bank_a [COEF_DEPTH];
  logic signed [B_W-1:0] bank_b [COEF_DEPTH];

  // Coefficient banks: written on any edge with coef_we, regardless of ena
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < COEF_DEPTH; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
    end else if (coef_we) begin
      if (coef_bank) bank_b[coef_waddr] <= coef_wdata;
      else           bank_a[coef_waddr] <= coef_wdata;
    end
  end

  logic                    vld_p0, pre_p0, sub_p0, neg_p0, ld_p0, clr_p0;
  logic [1:0]              mode_p0;
  logic signed [A_W-1:0]   ay_p0, az_p0, by_p0, bz_p0;
  logic signed [B_W-1:0]   ma_p0, mb_p0;
  logic signed [ACC_W-1:0] chain_p0, const_p0;

  // Stage p0: input register; coefficients are read here
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vld_p0   <= 1'b0;
      mode_p0  <= '0;
      pre_p0   <= 1'b0;
      sub_p0   <= 1'b0;
      neg_p0   <= 1'b0;
      ld_p0    <= 1'b0;
      clr_p0   <= 1'b0;
      ay_p0    <= '0;
      az_p0    <= '0;
      by_p0    <= '0;
      bz_p0    <= '0;
      ma_p0    <= '0;
      mb_p0    <= '0;
      chain_p0 <= '0;
      const_p0 <= '0;
    end else if (ena) begin
      vld_p0   <= in_valid;
      mode_p0  <= mode;
      pre_p0   <= preadd_en;
      sub_p0   <= sub;
      neg_p0   <= negate;
      ld_p0    <= loadconst;
      clr_p0   <= clear_acc;
      ay_p0    <= ay;
      az_p0    <= az;
      by_p0    <= by;
      bz_p0    <= bz;
      ma_p0    <= coefmux ? bank_a[coefsela] : ax;
      mb_p0    <= coefmux ? bank_b[coefselb] : bx;
      chain_p0 <= chainin;
      const_p0 <= constant;
    end
  end

  logic signed [PA_W-1:0] pa_p0, pb_p0;
  logic signed [P_W-1:0]  pra_p0, prb_p0;
  logic signed [S_W-1:0]  sum_p0, s_p0;
  logic [BUN_W-1:0]       bun_p0;

  always_comb begin
    pa_p0  = pre_p0 ? PA_W'(ay_p0) + PA_W'(az_p0) : PA_W'(ay_p0);
    pb_p0  = pre_p0 ? PA_W'(by_p0) + PA_W'(bz_p0) : PA_W'(by_p0);
    pra_p0 = P_W'(pa_p0) * P_W'(ma_p0);
    prb_p0 = P_W'(pb_p0) * P_W'(mb_p0);
    sum_p0 = sub_p0 ? S_W'(pra_p0) - S_W'(prb_p0) : S_W'(pra_p0) + S_W'(prb_p0);
    s_p0   = neg_p0 ? -sum_p0 : sum_p0;
    bun_p0 = {vld_p0, mode_p0, clr_p0, ld_p0, pra_p0, prb_p0, s_p0, chain_p0, const_p0};
  end

  logic [BUN_W-1:0] stage_q [PQ];

  // Stages p1..pPIPE: products, sum and controls travel together
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < PQ; i++) stage_q[i] <= '0;
    end else if (ena) begin
      stage_q[0] <= bun_p0;
      for (int i = 1; i < PQ; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  logic [BUN_W-1:0] bun_pn;

  generate
    if (PIPE == 0) begin : g_nopipe
      assign bun_pn = bun_p0;
    end else begin : g_pipe
      assign bun_pn = stage_q[PIPE-1];
    end
  endgenerate

  logic                    vld_pn, clr_pn, ld_pn, ovf_pn;
  logic [1:0]              mode_pn;
  logic signed [P_W-1:0]   pra_pn, prb_pn;
  logic signed [S_W-1:0]   s_pn;
  logic signed [ACC_W-1:0] chain_pn, const_pn, s_ext_pn, base_pn, sum_pn, acc_q;

  assign {vld_pn, mode_pn, clr_pn, ld_pn, pra_pn, prb_pn, s_pn, chain_pn, const_pn} = bun_pn;

  // Accumulator feedback comes from acc_q, so the loop is one cycle at any PIPE
  always_comb begin
    s_ext_pn = ACC_W'(s_pn);
    base_pn  = chain_pn;
    if (mode_pn == 2'b10) base_pn = clr_pn ? '0 : (ld_pn ? const_pn : acc_q);
    {ovf_pn, sum_pn} = add_sat(base_pn, s_ext_pn);
  end

  // Output stage: results, accumulator and sticky overflow
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      out_valid <= 1'b0;
      resulta   <= '0;
      resultb   <= '0;
      chainout  <= '0;
      acc_q     <= '0;
      overflow  <= 1'b0;
    end else if (ena) begin
      out_valid <= vld_pn;
      if (vld_pn) begin
        resulta <= pra_pn;
        resultb <= prb_pn;
        case (mode_pn)
          2'b01: chainout <= s_ext_pn;
          2'b10: begin
            acc_q    <= sum_pn;
            chainout <= sum_pn;
            if (ovf_pn)      overflow <= 1'b1;
            else if (clr_pn) overflow <= 1'b0;
          end
          2'b11: begin
            chainout <= sum_pn;
            if (ovf_pn) overflow <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsp_slice_pipe.sv
// Directed-vector bench for dsp_slice_pipe with an in-order reference model
// and a per-cycle output monitor.
module tb_dsp_slice_pipe;

  localparam int A_W   = 19;
  localparam int B_W   = 18;
  localparam int CD    = 8;
  localparam int PIPE  = 2;
  localparam int ACC_W = 64;
  localparam int SAT   = 1;
  localparam int CS_W  = 3;
  localparam int P_W   = A_W + B_W + 1;
  localparam int W2    = ACC_W + 2;

  logic clk = 1'b0;
  logic clr_n = 1'b1;
  logic ena = 1'b1;
  logic in_valid = 1'b0;
  logic [1:0] mode = '0;
  logic preadd_en = 0, sub = 0, negate = 0, loadconst = 0, clear_acc = 0, coefmux = 0;
  logic signed [A_W-1:0] ay = '0, az = '0, by = '0, bz = '0;
  logic signed [B_W-1:0] ax = '0, bx = '0;
  logic [CS_W-1:0] coefsela = '0, coefselb = '0, coef_waddr = '0;
  logic coef_we = 1'b0, coef_bank = 1'b0;
  logic signed [B_W-1:0] coef_wdata = '0;
  logic signed [ACC_W-1:0] chainin = '0, constant = '0;
  logic signed [P_W-1:0] resulta, resultb;
  logic signed [ACC_W-1:0] chainout;
  logic out_valid, overflow;

  dsp_slice_pipe #(.A_W(A_W), .B_W(B_W), .COEF_DEPTH(CD), .PIPE(PIPE),
                   .ACC_W(ACC_W), .SAT(SAT)) dut (
    .clk(clk), .clr_n(clr_n), .ena(ena), .in_valid(in_valid), .mode(mode),
    .preadd_en(preadd_en), .sub(sub), .negate(negate), .loadconst(loadconst),
    .clear_acc(clear_acc), .coefmux(coefmux), .ay(ay), .az(az), .by(by), .bz(bz),
    .ax(ax), .bx(bx), .coefsela(coefsela), .coefselb(coefselb), .coef_we(coef_we),
    .coef_bank(coef_bank), .coef_waddr(coef_waddr), .coef_wdata(coef_wdata),
    .chainin(chainin), .constant(constant), .resulta(resulta), .resultb(resultb),
    .chainout(chainout), .out_valid(out_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic pre, sub, neg, ld, clr, cmux;
    int ay, az, by, bz, ax, bx, csa, csb;
    logic signed [ACC_W-1:0] cin, cst;
  } op_t;

  typedef struct {
    int due;
    logic signed [P_W-1:0] ra, rb;
    logic signed [ACC_W-1:0] co;
    logic ovf;
  } exp_t;

  int vectors = 0;
  int miscompares = 0;
  int enabled_edges = 0;
  exp_t q[$];
  exp_t cur, e;

  // Architectural state of the slice as seen by a programmer
  logic signed [ACC_W-1:0] m_acc, m_co;
  logic signed [P_W-1:0] m_ra, m_rb;
  logic m_ovf;
  int m_bank_a [CD];
  int m_bank_b [CD];

  task automatic chk_w(input string nm, input logic signed [ACC_W-1:0] act, input logic signed [ACC_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_p(input string nm, input logic signed [P_W-1:0] act, input logic signed [P_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b, want %0b", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = '0; m_co = '0; m_ra = '0; m_rb = '0; m_ovf = 1'b0;
    for (int i = 0; i < CD; i++) begin
      m_bank_a[i] = 0;
      m_bank_b[i] = 0;
    end
    q.delete();
  endtask

  // Executes one operation on the architectural state, in program order
  task automatic model(input op_t o, output exp_t r);
    longint pa, pb, ba, bb, pra, prb, s;
    logic signed [W2-1:0] base, wide, hi, lo;
    logic signed [ACC_W-1:0] res;
    logic ov;
    pa  = o.pre ? longint'(o.ay) + longint'(o.az) : longint'(o.ay);
    pb  = o.pre ? longint'(o.by) + longint'(o.bz) : longint'(o.by);
    ba  = o.cmux ? longint'(m_bank_a[o.csa]) : longint'(o.ax);
    bb  = o.cmux ? longint'(m_bank_b[o.csb]) : longint'(o.bx);
    pra = pa * ba;
    prb = pb * bb;
    s   = o.sub ? pra - prb : pra + prb;
    if (o.neg) s = -s;
    m_ra = P_W'(pra);
    m_rb = P_W'(prb);
    hi = W2'(1);
    hi = (hi <<< (ACC_W - 1)) - W2'(1);
    lo = -hi - W2'(1);
    if (o.mode == 2'b10) base = o.clr ? W2'(0) : (o.ld ? W2'(o.cst) : W2'(m_acc));
    else                 base = W2'(o.cin);
    wide = base + W2'(s);
    ov   = (wide > hi) || (wide < lo);
    res  = ACC_W'(wide);
    if (ov && SAT != 0) res = (wide > hi) ? ACC_W'(hi) : ACC_W'(lo);
    case (o.mode)
      2'b01: m_co = ACC_W'(s);
      2'b10: begin
        m_acc = res;
        m_co  = res;
        if (ov)         m_ovf = 1'b1;
        else if (o.clr) m_ovf = 1'b0;
      end
      2'b11: begin
        m_co = res;
        if (ov) m_ovf = 1'b1;
      end
      default: ;
    endcase
    r.due = 0; r.ra = m_ra; r.rb = m_rb; r.co = m_co; r.ovf = m_ovf;
  endtask

  function automatic op_t mk(input logic [1:0] m, input int ay_v, input int ax_v,
                             input int by_v, input int bx_v);
    op_t o;
    o = '{default: 0};
    o.mode = m; o.ay = ay_v; o.ax = ax_v; o.by = by_v; o.bx = bx_v;
    return o;
  endfunction

  task automatic apply(input op_t o, input logic cw, input logic cb, input int ca,
                       input int cd, output exp_t r);
    @(negedge clk);
    mode = o.mode; preadd_en = o.pre; sub = o.sub; negate = o.neg;
    loadconst = o.ld; clear_acc = o.clr; coefmux = o.cmux;
    ay = A_W'(o.ay); az = A_W'(o.az); by = A_W'(o.by); bz = A_W'(o.bz);
    ax = B_W'(o.ax); bx = B_W'(o.bx);
    coefsela = CS_W'(o.csa); coefselb = CS_W'(o.csb);
    chainin = o.cin; constant = o.cst;
    coef_we = cw; coef_bank = cb; coef_waddr = CS_W'(ca); coef_wdata = B_W'(cd);
    in_valid = 1'b1;
    model(o, r);
    r.due = enabled_edges + PIPE + 2;
    q.push_back(r);
    if (cw) begin
      if (cb) m_bank_b[ca] = cd;
      else    m_bank_a[ca] = cd;
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    coef_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Output monitor: every enabled edge is checked against the model queue,
  // every stalled edge must leave the outputs untouched.
  logic signed [P_W-1:0] sn_ra, sn_rb;
  logic signed [ACC_W-1:0] sn_co;
  logic sn_v, sn_o;

  always @(posedge clk) begin
    if (clr_n && ena) begin
      enabled_edges++;
      #1;
      if (out_valid) begin
        if (q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL spurious_valid: out_valid got 1 with no result outstanding");
        end else begin
          cur = q.pop_front();
          chk_i("latency", enabled_edges, cur.due);
          chk_p("resulta", resulta, cur.ra);
          chk_p("resultb", resultb, cur.rb);
          chk_w("chainout", chainout, cur.co);
          chk_b("overflow", overflow, cur.ovf);
        end
      end else if (q.size() != 0 && q[0].due <= enabled_edges) begin
        vectors++; miscompares++;
        $display("FAIL missing_result: out_valid got 0, want 1 at edge %0d", q[0].due);
        void'(q.pop_front());
      end
    end else if (clr_n) begin
      sn_ra = resulta; sn_rb = resultb; sn_co = chainout; sn_v = out_valid; sn_o = overflow;
      #1;
      chk_p("stall_resulta", resulta, sn_ra);
      chk_p("stall_resultb", resultb, sn_rb);
      chk_w("stall_chainout", chainout, sn_co);
      chk_b("stall_out_valid", out_valid, sn_v);
      chk_b("stall_overflow", overflow, sn_o);
    end
  end

  op_t o;

  initial begin
    model_reset();
    #2 clr_n = 1'b0;
    #1;
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_w("rst_chainout", chainout, '0);
    chk_p("rst_resulta", resulta, '0);
    chk_b("rst_overflow", overflow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    idle(2);

    // Latency and mode 01
    o = mk(2'b01, 3, 4, -5, 6); o.az = 2; o.pre = 1'b1;
    apply(o, 1'b0, 1'b0, 0, 0, e);
    chk_w("pin_sum_co", e.co, -64'sd10);
    chk_p("pin_sum_ra", e.ra, P_W'(20));
    chk_p("pin_sum_rb", e.rb, P_W'(-30));
    repeat (2) @(posedge clk);
    #1 chk_b("lat_not_yet", out_valid, 1'b0);
    @(posedge clk);
    #1 chk_b("lat_arrived", out_valid, 1'b1);
    idle(2);

    // Accumulate back to back, then clear
    o = mk(2'b10, 7, 1, 0, 0); o.ld = 1'b1; o.cst = 64'sd100;
    apply(o, 1'b0, 1'b0, 0, 0, e);
    chk_w("pin_acc0", e.co, 64'sd107);
    o.ld = 1'b0;
    apply(o, 1'b0, 1'b0, 0, 0, e);
    chk_w("pin_acc1", e.co, 64'sd114);
    apply(o, 1'b0, 1'b0, 0, 0, e);
    chk_w("pin_acc2", e.co, 64'sd121);
    o = mk(2'b10, 1, 1, 0, 0); o.clr = 1'b1;
    apply(o, 1'b0, 1'b0, 0, 0, e);
    chk_w("pin_acc_clr", e.co, 64'sd1);
    idle(3);

    // Positive saturation, sticky flag, negative saturation, clean clear
    o = mk(2'b10, 20, 1, 0, 0); o.ld = 1'b1; o.cst = 64'sh7FFF_FFFF_FFFF_FFF6;
    apply(o, 1'b0, 1'b0, 0, 0, e);
    chk_w("pin_sat_hi", e.co, 64'sh7FFF_FFFF_FFFF_FFFF);
    chk_b("pin_sat_flag", e.ovf, 1'b1);
    o = mk(2'b01, 2, 2, 0, 0);
    apply(o, 1'b0, 1'b0, 0, 0, e);
    o = mk(2'b10, 20, 1, 0, 0); o.neg = 1'b1; o.ld = 1'b1; o.cst = 64'sh8000_0000_0000_0005;
    apply(o, 1'b0, 1'b0, 0, 0, e);
    chk_w("pin_sat_lo", e.co, 64'sh8000_0000_0000_0000);
    o = mk(2'b10, 1, 1, 0, 0); o.clr = 1'b1;
    apply(o, 1'b0, 1'b0, 0, 0, e);
    chk_b("pin_sat_clear", e.ovf, 1'b0);
    idle(3);

    // Coefficient write with same-edge read, then the new value
    o = mk(2'b00, 11, 9, 0, 0); o.cmux = 1'b1; o.csa = 5;
    apply(o, 1'b1, 1'b0, 5, -3, e);
    chk_p("pin_coef_old", e.ra, P_W'(0));
    apply(o, 1'b0, 1'b0, 0, 0, e);
    chk_p("pin_coef_new", e.ra, P_W'(-33));
    idle(3);

    // Burst with a 3-cycle stall, a stalled coefficient write and a chain add
    o = mk(2'b01, 2, 3, 0, 0);
    apply(o, 1'b0, 1'b0, 0, 0, e);
    o = mk(2'b11, 1, 1, 0, 0); o.neg = 1'b1; o.cin = 64'sd1000;
    apply(o, 1'b0, 1'b0, 0, 0, e);
    chk_w("pin_chain", e.co, 64'sd999);
    o = mk(2'b00, 4, 5, 2, 3);
    apply(o, 1'b0, 1'b0, 0, 0, e);
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    coef_we = 1'b1; coef_bank = 1'b1; coef_waddr = 3'd3; coef_wdata = 18'sd4;
    m_bank_b[3] = 4;
    @(negedge clk);
    coef_we = 1'b0;
    idle(2);
    ena = 1'b1;
    o = mk(2'b00, 0, 0, 5, 0); o.cmux = 1'b1; o.csb = 3;
    apply(o, 1'b0, 1'b0, 0, 0, e);
    chk_p("pin_coef_b", e.rb, P_W'(20));
    idle(5);

    // Asynchronous reset with one result showing and one in flight
    o = mk(2'b10, 5, 5, 0, 0); o.ld = 1'b1; o.cst = 64'sd50;
    apply(o, 1'b0, 1'b0, 0, 0, e);
    apply(o, 1'b0, 1'b0, 0, 0, e);
    repeat (2) @(posedge clk);
    #3 clr_n = 1'b0;
    #1;
    chk_b("arst_out_valid", out_valid, 1'b0);
    chk_w("arst_chainout", chainout, '0);
    chk_p("arst_resultb", resultb, '0);
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;
    idle(6);
    o = mk(2'b10, 11, 0, 0, 0); o.cmux = 1'b1; o.csa = 5;
    apply(o, 1'b0, 1'b0, 0, 0, e);
    chk_w("pin_post_rst", e.co, 64'sd0);
    idle(6);

    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drained: got %0d results outstanding, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
